// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - command/response handshake bundle for alu_sequencer
// Ports (signals carried):
//   cmd_valid/cmd_ready, cmd_op[3:0], cmd_a[3:0], cmd_b[3:0]  command channel
//   rsp_valid/rsp_ready, rsp_r[7:0], rsp_zero/carry/sign/err   response channel
// master: the issuing control unit; slave: the sequencer.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_r;
    logic       rsp_zero;
    logic       rsp_carry;
    logic       rsp_sign;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_sign, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_r, rsp_zero, rsp_carry, rsp_sign, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer around a 4-bit ALU, incl. shift-add multiply
// Purpose: accepts one command at a time, runs it on the ALU (one cycle, or four
//          shift-add iterations for MUL) and holds the result until taken.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset
//   s      alu_sequencer_if.slave command/response channels
// alu ports: l (1 = logic op), alu_op[1:0], a/b[3:0] in; r[3:0], carry out.

module alu (
    input  logic       l,
    input  logic [1:0] alu_op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] r,
    output logic       carry
);
    logic [4:0] sum;

    always_comb begin
        sum   = 5'd0;
        r     = 4'd0;
        carry = 1'b0;
        if (!l) begin
            // Negation and subtraction use invert-plus-one, so carry means "no borrow".
            case (alu_op)
                2'b00:   sum = {1'b0, ~a} + 5'd1;
                2'b01:   sum = {1'b0, ~b} + 5'd1;
                2'b10:   sum = {1'b0, a} + {1'b0, b};
                default: sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
            endcase
            r     = sum[3:0];
            carry = sum[4];
        end else begin
            case (alu_op)
                2'b00:   r = a & b;
                2'b01:   r = a | b;
                2'b10:   r = a ^ b;
                default: r = ~a;
            endcase
        end
    end
endmodule

module alu_sequencer #(
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    alu_sequencer_if.slave  s
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] a_q, a_d;       // operand A; multiplicand M during MUL
    logic [3:0] b_q, b_d;       // operand B; low product half P_lo during MUL
    logic [3:0] p_hi_q, p_hi_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] rsp_r_q, rsp_r_d;
    logic       rsp_zero_q, rsp_zero_d;
    logic       rsp_carry_q, rsp_carry_d;
    logic       rsp_sign_q, rsp_sign_d;
    logic       rsp_err_q, rsp_err_d;

    logic       alu_l;
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b, alu_r;
    logic       alu_carry;
    logic       cmd_is_mul, op_is_illegal;
    logic [7:0] mul_prod;

    assign cmd_is_mul    = (s.cmd_op == 4'b1000) && (MUL_EN != 0);
    assign op_is_illegal = op_q[3] && !((op_q == 4'b1000) && (MUL_EN != 0));
    // Product after this iteration: shifted-in sum on top, P_lo shifted right.
    assign mul_prod      = {alu_carry, alu_r, b_q[3:1]};

    alu u_alu (
        .l      (alu_l),
        .alu_op (alu_op),
        .a      (alu_a),
        .b      (alu_b),
        .r      (alu_r),
        .carry  (alu_carry)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'd0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            p_hi_q      <= 4'd0;
            cnt_q       <= 2'd0;
            rsp_r_q     <= 8'd0;
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_sign_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            p_hi_q      <= p_hi_d;
            cnt_q       <= cnt_d;
            rsp_r_q     <= rsp_r_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_sign_q  <= rsp_sign_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s.cmd_valid) state_d = cmd_is_mul ? MUL : EXEC;
            EXEC:    state_d = DONE;
            MUL:     if (cnt_q == 2'd3) state_d = DONE;
            default: if (s.rsp_ready) state_d = IDLE;
        endcase
    end

    // ALU drive: only latched registers ever reach the ALU.
    always_comb begin
        alu_l  = op_q[2];
        alu_op = op_q[1:0];
        alu_a  = a_q;
        alu_b  = b_q;
        if (state_q == MUL) begin
            alu_l  = 1'b0;
            alu_op = 2'b10;
            alu_a  = p_hi_q;
            alu_b  = b_q[0] ? a_q : 4'd0;
        end
    end

    // Datapath register updates
    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        p_hi_d      = p_hi_q;
        cnt_d       = cnt_q;
        rsp_r_d     = rsp_r_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_carry_d = rsp_carry_q;
        rsp_sign_d  = rsp_sign_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (s.cmd_valid) begin
                    op_d   = s.cmd_op;
                    a_d    = s.cmd_a;
                    b_d    = s.cmd_b;
                    p_hi_d = 4'd0;
                    cnt_d  = 2'd0;
                end
            end
            EXEC: begin
                if (op_is_illegal) begin
                    rsp_r_d     = 8'd0;
                    rsp_zero_d  = 1'b0;
                    rsp_carry_d = 1'b0;
                    rsp_sign_d  = 1'b0;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_r_d     = {4'd0, alu_r};
                    rsp_zero_d  = (alu_r == 4'd0);
                    rsp_carry_d = alu_carry;
                    rsp_sign_d  = alu_r[3];
                    rsp_err_d   = 1'b0;
                end
            end
            MUL: begin
                p_hi_d = mul_prod[7:4];
                b_d    = mul_prod[3:0];
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    rsp_r_d     = mul_prod;
                    rsp_zero_d  = (mul_prod == 8'd0);
                    rsp_carry_d = 1'b0;
                    rsp_sign_d  = mul_prod[7];
                    rsp_err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        s.cmd_ready = (state_q == IDLE);
        s.rsp_valid = (state_q == DONE);
        s.rsp_r     = rsp_r_q;
        s.rsp_zero  = rsp_zero_q;
        s.rsp_carry = rsp_carry_q;
        s.rsp_sign  = rsp_sign_q;
        s.rsp_err   = rsp_err_q;
    end
endmodule
